uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver in the serial path.
//  Deserialises UART_RX into words of DATA_BITS bits, with optional parity and 1/2 stop bits.
//  Uses 3-sample majority voting and glitch-rejecting start validation.
//  Flags framing, parity, break and overrun, and delivers words on a valid/ready handshake.
//  Sits between the board RX pin (via baud_clk tick domain) and the host-side command/FIFO logic.
// PARAMETERS
//  OVERSAMPLE  16  baud_clk cycles per bit; even, >=8
//  DATA_BITS   8   data bits per frame, 5..9
//  PARITY      0   0=none, 1=odd, 2=even
//  STOP_BITS   1   stop bits checked, 1 or 2
// PORTS
//  baud_clk    in   1          clock, OVERSAMPLE x bit rate
//  reset       in   1          synchronous reset, active-low
//  UART_RX     in   1          asynchronous serial line, idle high
//  RX_DATA     out  DATA_BITS  received word, LSB = first bit on line
//  RX_VALID    out  1          RX_DATA and error flags valid
//  RX_READY    in   1          consumer accepts word when RX_VALID&&RX_READY
//  FRAME_ERR   out  1          word had a low stop bit (qualified by RX_VALID)
//  PARITY_ERR  out  1          parity mismatch (qualified by RX_VALID; 0 when PARITY=0)
//  RX_BREAK    out  1          one-cycle pulse: all data, parity and stop bits sampled 0
//  OVERRUN     out  1          one-cycle pulse: frame completed while RX_VALID&&!RX_READY
//  RX_BUSY     out  1          high whenever state != IDLE
// BEHAVIOUR
//  - Reset (reset==0 at posedge baud_clk): state=IDLE, counters 0, 2-flop sync chain=1,
//    RX_DATA=0, RX_VALID=0, FRAME_ERR=0, PARITY_ERR=0, RX_BREAK=0, OVERRUN=0, RX_BUSY=0.
//    Reset mid-frame abandons the frame; no word is delivered.
//  - UART_RX passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
//  - tick counts 0..OVERSAMPLE-1 within each bit.
//  - Vote = majority of rx_s at tick M-1, M, M+1, where M=OVERSAMPLE/2. Decision taken at tick M+1.
//  - States: IDLE, START, DATA, PAR, STOP, BRK_WAIT.
//    IDLE: rx_s==0 -> START, tick=0.
//    START: at decision, vote==1 -> IDLE (glitch rejected, no flags).
//      Else, at tick OVERSAMPLE-1 -> DATA, bit index=0.
//    DATA: at decision, shift vote in at MSB side (LSB-first line order).
//      At tick OVERSAMPLE-1: after bit DATA_BITS-1 -> PAR if PARITY!=0, else STOP.
//    PAR: at decision, store vote.
//      Error if odd: XOR(data,p)!=1; even: XOR(data,p)!=0. At tick OVERSAMPLE-1 -> STOP.
//    STOP: at decision, vote==0 sets frame error.
//      If STOP_BITS==2 and this is the first stop bit: continue to the second stop bit;
//      the frame error from both stop bits ORs.
//      At decision of the last stop bit: complete the frame immediately, without waiting out the bit.
//      Then go to BRK_WAIT if break, else to IDLE.
//    BRK_WAIT: stay until rx_s==1, then IDLE. No start detection while in BRK_WAIT.
//  - Completion (cycle after the last stop decision):
//    RX_VALID==0 or RX_READY==1: load RX_DATA, FRAME_ERR, PARITY_ERR; RX_VALID=1.
//    Otherwise: keep the old word and flags, pulse OVERRUN.
//  - Break: RX_BREAK pulses on completion; the word (0) is still delivered with FRAME_ERR=1.
//  - Handshake: RX_VALID falls the cycle after RX_VALID&&RX_READY, unless a completion loads in the same cycle.
//    Simultaneous accept+completion: new word loaded, RX_VALID stays 1, no OVERRUN.
//    RX_DATA and flags are stable while RX_VALID&&!RX_READY.
//  - Latency: last stop decision to RX_VALID rise = 1 cycle.
// TESTING
//  1 8N1, line bits for 0xA5, RX_READY=1 -> RX_VALID one cycle, RX_DATA=0xA5, FRAME_ERR=0, PARITY_ERR=0.
//  2 PARITY=2, 0x37 with parity bit 0 (wrong, expects 1) -> RX_DATA=0x37, PARITY_ERR=1.
//    Same word with parity bit 1 -> PARITY_ERR=0.
//  3 Start pulse low for 3 baud_clk then high -> RX_BUSY pulses, returns to IDLE, RX_VALID stays 0.
//  4 Line held low 12 bit times -> RX_DATA=0x00, FRAME_ERR=1, RX_BREAK pulse.
//    No new frame until the line returns high.
//  5 Send 0x11 then 0x22 with RX_READY=0 -> RX_DATA stays 0x11, OVERRUN pulses once.
//    Then raise RX_READY -> RX_VALID drops.
//  6 Assert reset mid-data bit 4 of 0xFF, release, send 0x5A -> only 0x5A delivered.
//  7 STOP_BITS=2, second stop bit low -> FRAME_ERR=1.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - received-word handshake bundle between the UART receiver and its consumer
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] RX_DATA;
    logic                 RX_VALID;
    logic                 RX_READY;
    logic                 FRAME_ERR;
    logic                 PARITY_ERR;
    logic                 RX_BREAK;
    logic                 OVERRUN;

    modport master (
        output RX_DATA, RX_VALID, FRAME_ERR, PARITY_ERR, RX_BREAK, OVERRUN,
        input  RX_READY
    );

    modport slave (
        input  RX_DATA, RX_VALID, FRAME_ERR, PARITY_ERR, RX_BREAK, OVERRUN,
        output RX_READY
    );
endinterface

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote, parity/stop checks and break/overrun flags
module uart_rx_os #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        baud_clk,
    input  logic        reset,
    input  logic        UART_RX,
    output logic        RX_BUSY,
    uart_rx_os_if.master rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_BRK   = 3'd5;

    logic                 rx_m, rx_s;
    logic [2:0]           state;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 s_pre, s_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 all_zero;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 valid_q, ferr_q, perr_q, brk_q, ovr_q;

    logic vote, decision, bit_end, last_stop, complete;
    logic fin_ferr, fin_brk, fin_perr, parity_x;

    always_comb begin
        vote      = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);
        decision  = (tick == T_DEC);
        bit_end   = (tick == T_LAST);
        last_stop = (STOP_BITS != 2) | stop_idx;
        complete  = (state == ST_STOP) && decision && last_stop;
        fin_ferr  = ferr_acc | ~vote;
        fin_brk   = all_zero & ~vote;
        parity_x  = (^shreg) ^ par_bit;
        fin_perr  = (PARITY == 1) ? ~parity_x : (PARITY == 2) ? parity_x : 1'b0;
    end

    always_ff @(posedge baud_clk) begin
        if (!reset) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            state    <= ST_IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            s_pre    <= 1'b1;
            s_mid    <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
            all_zero <= 1'b0;
        end else begin
            rx_m <= UART_RX;
            rx_s <= rx_m;
            if (tick == T_PRE) s_pre <= rx_s;
            if (tick == T_MID) s_mid <= rx_s;
            tick <= (state == ST_IDLE || state == ST_BRK || bit_end) ? '0 : tick + 1'b1;

            case (state)
                ST_IDLE: if (!rx_s) state <= ST_START;
                ST_START: begin
                    if (decision && vote) begin
                        state <= ST_IDLE;
                        tick  <= '0;
                    end else if (bit_end) begin
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        ferr_acc <= 1'b0;
                        all_zero <= 1'b1;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first, so each new bit enters at the top and walks down
                    if (decision) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (vote) all_zero <= 1'b0;
                    end
                    if (bit_end) begin
                        if (bit_idx == B_LAST) state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                        else                   bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_PAR: begin
                    if (decision) begin
                        par_bit <= vote;
                        if (vote) all_zero <= 1'b0;
                    end
                    if (bit_end) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (decision) begin
                        if (!vote) ferr_acc <= 1'b1;
                        if (vote)  all_zero <= 1'b0;
                        // last stop bit ends the frame mid-bit so a back-to-back start is not missed
                        if (last_stop) begin
                            state <= fin_brk ? ST_BRK : ST_IDLE;
                            tick  <= '0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                ST_BRK:  if (rx_s) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge baud_clk) begin
        if (!reset) begin
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            brk_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            brk_q <= complete & fin_brk;
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || rx.RX_READY) begin
                    rx_data_q <= shreg;
                    ferr_q    <= fin_ferr;
                    perr_q    <= fin_perr;
                    valid_q   <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx.RX_READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.RX_DATA    = rx_data_q;
    assign rx.RX_VALID   = valid_q;
    assign rx.FRAME_ERR  = ferr_q;
    assign rx.PARITY_ERR = perr_q;
    assign rx.RX_BREAK   = brk_q;
    assign rx.OVERRUN    = ovr_q;
    assign RX_BUSY       = (state != ST_IDLE);
endmodule
